// File: rtl/bram_sched_pkg.sv
// Shared definitions for the BRAM burst scheduler: FSM encoding,
// requester index constants and burst length field width.
package bram_sched_pkg;

    // Burst length field width (beats-1, 0..15)
    localparam int LEN_W = 4;

    // FSM encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    // Requester slots
    localparam int REQ_CACHE  = 0;
    localparam int REQ_DMA_WR = 1;
    localparam int REQ_DMA_RD = 2;

endpackage

// File: rtl/bram_burst_scheduler_rr_picker.sv
// rr_picker: round-robin search over N request lines starting at ptr.
// Returns a one-hot grant, the binary index of the winner and an
// "any request" flag. Purely combinational.
module rr_picker #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int   cand_s;
    logic found_s;

    // First valid request found walking upward from ptr, wrapping at N
    always_comb begin
        gnt     = {N{1'b0}};
        idx     = {IW{1'b0}};
        found_s = 1'b0;
        cand_s  = 0;
        for (int k = 0; k < N; k++) begin
            cand_s = int'(ptr) + k;
            if (cand_s >= N) begin
                cand_s = cand_s - N;
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req[cand_s]) begin
                found_s     = 1'b1;
                idx         = IW'(cand_s);
                gnt[cand_s] = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        any = |req;
    end

endmodule

// File: rtl/bram_burst_scheduler.sv
// bram_burst_scheduler: time-shares one single-port BRAM among NREQ
// burst requesters (0 = cache refill, 1 = DMA write, 2 = DMA read).
// One BRAM access per cycle; read data returns BRAM_LAT cycles after
// the issuing beat, tagged with the owning requester.
// Optional feature macro: BRAM_SCHED_PRIO_EN -- requester 0 wins every
// idle arbitration it takes part in; others share round-robin.
module bram_burst_scheduler
    import bram_sched_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int AW       = 13,
    parameter int DW       = 32,
    parameter int BRAM_LAT = 2
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*LEN_W-1:0] req_len,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      beat,
    output logic [NREQ-1:0]      rd_valid,
    output logic [DW-1:0]        rd_data,
    output logic                 rd_last,
    output logic                 busy,
    output logic                 bram_en,
    output logic                 bram_we,
    output logic [AW-1:0]        bram_addr,
    output logic [DW-1:0]        bram_wdata,
    input  logic [DW-1:0]        bram_rdata
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Wrap-around increment of a requester index
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (i == IW'(NREQ - 1)) begin
            return {IW{1'b0}};
        end else begin
            return i + IW'(1);
        end
    endfunction

    logic [0:0]       state_r;
    logic [IW-1:0]    owner_r;
    logic [LEN_W-1:0] cnt_r;
    logic [AW-1:0]    addr_r;
    logic [IW-1:0]    rr_ptr_r;

    logic [BRAM_LAT-1:0]         pipe_vld_r;
    logic [BRAM_LAT-1:0]         pipe_last_r;
    logic [BRAM_LAT-1:0][IW-1:0] pipe_own_r;

    logic [IW-1:0]    pick_ptr_s;
    logic [NREQ-1:0]  pick_gnt_s;
    logic [IW-1:0]    pick_idx_s;
    logic             pick_any_s;

    logic [IW-1:0]    cur_idx_s;
    logic [AW-1:0]    cur_addr_s;
    logic             sel_valid_s;
    logic             sel_we_s;
    logic [AW-1:0]    sel_addr_s;
    logic [LEN_W-1:0] sel_len_s;
    logic [DW-1:0]    sel_wdata_s;
    logic             issue_s;
    logic             start_s;
    logic             last_s;
    logic             abort_s;
    logic             out_vld_s;

    // Search origin: cache refill jumps the queue when prioritised
    always_comb begin
`ifdef BRAM_SCHED_PRIO_EN
        if (req_valid[REQ_CACHE]) begin
            pick_ptr_s = IW'(REQ_CACHE);
        end else begin
            pick_ptr_s = rr_ptr_r;
        end
`else
        pick_ptr_s = rr_ptr_r;
`endif
    end

    rr_picker #(.N(NREQ), .IW(IW)) u_picker (
        .req (req_valid),
        .ptr (pick_ptr_s),
        .gnt (pick_gnt_s),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

    // Active requester: fresh winner when idle, burst owner otherwise
    always_comb begin
        if (state_r == ST_IDLE) begin
            cur_idx_s = pick_idx_s;
        end else begin
            cur_idx_s = owner_r;
        end
    end

    // Fetch the request fields of the active requester
    always_comb begin
        sel_valid_s = 1'b0;
        sel_we_s    = 1'b0;
        sel_addr_s  = {AW{1'b0}};
        sel_len_s   = {LEN_W{1'b0}};
        sel_wdata_s = {DW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == cur_idx_s) begin
                sel_valid_s = req_valid[i];
                sel_we_s    = req_we[i];
                sel_addr_s  = req_addr[i*AW +: AW];
                sel_len_s   = req_len[i*LEN_W +: LEN_W];
                sel_wdata_s = req_wdata[i*DW +: DW];
            end else begin
                sel_valid_s = sel_valid_s;
            end
        end
    end

    // Beat issue decision, last-beat and abort detection
    always_comb begin
        issue_s    = 1'b0;
        start_s    = 1'b0;
        last_s     = 1'b0;
        abort_s    = 1'b0;
        cur_addr_s = addr_r;
        if (wb_rst_i) begin
            issue_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            if (pick_any_s) begin
                issue_s    = 1'b1;
                start_s    = 1'b1;
                cur_addr_s = sel_addr_s;
                last_s     = (sel_len_s == {LEN_W{1'b0}});
            end else begin
                issue_s = 1'b0;
            end
        end else begin
            if (sel_valid_s) begin
                issue_s = 1'b1;
                last_s  = (cnt_r == {LEN_W{1'b0}});
            end else begin
                abort_s = 1'b1;
            end
        end
    end

    // Requester-facing and BRAM-facing outputs
    always_comb begin
        gnt        = {NREQ{1'b0}};
        beat       = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == cur_idx_s) begin
                gnt[i]  = !wb_rst_i && ((state_r == ST_BURST) || pick_any_s);
                beat[i] = issue_s;
            end else begin
                gnt[i]  = 1'b0;
            end
        end
        bram_en    = issue_s;
        bram_we    = issue_s && sel_we_s;
        bram_addr  = issue_s ? cur_addr_s : {AW{1'b0}};
        bram_wdata = (issue_s && sel_we_s) ? sel_wdata_s : {DW{1'b0}};
    end

    // Burst FSM, beat counter, running address and round-robin pointer
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r  <= ST_IDLE;
            owner_r  <= {IW{1'b0}};
            cnt_r    <= {LEN_W{1'b0}};
            addr_r   <= {AW{1'b0}};
            rr_ptr_r <= {IW{1'b0}};
        end else begin
            if (start_s && !last_s) begin
                state_r <= ST_BURST;
                owner_r <= cur_idx_s;
                cnt_r   <= sel_len_s - LEN_W'(1);
                addr_r  <= cur_addr_s + AW'(1);
            end else if (state_r == ST_BURST) begin
                if (issue_s) begin
                    cnt_r  <= cnt_r - LEN_W'(1);
                    addr_r <= addr_r + AW'(1);
                end
                if (last_s || abort_s) begin
                    state_r <= ST_IDLE;
                end
            end
            if ((issue_s && last_s) || abort_s) begin
                rr_ptr_r <= next_idx(cur_idx_s);
            end
        end
    end

    // Read-return tag pipeline: {owner, last} delayed by BRAM_LAT cycles
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pipe_vld_r  <= {BRAM_LAT{1'b0}};
            pipe_last_r <= {BRAM_LAT{1'b0}};
            pipe_own_r  <= '0;
        end else begin
            pipe_vld_r[0]  <= issue_s && !sel_we_s;
            pipe_last_r[0] <= last_s;
            pipe_own_r[0]  <= cur_idx_s;
            for (int i = 1; i < BRAM_LAT; i++) begin
                pipe_vld_r[i]  <= pipe_vld_r[i-1];
                pipe_last_r[i] <= pipe_last_r[i-1];
                pipe_own_r[i]  <= pipe_own_r[i-1];
            end
        end
    end

    assign out_vld_s = pipe_vld_r[BRAM_LAT-1] && !wb_rst_i;

    // Read return steering and activity flag
    always_comb begin
        rd_valid = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (pipe_own_r[BRAM_LAT-1] == IW'(i)) begin
                rd_valid[i] = out_vld_s;
            end else begin
                rd_valid[i] = 1'b0;
            end
        end
        rd_last = out_vld_s && pipe_last_r[BRAM_LAT-1];
        rd_data = out_vld_s ? bram_rdata : {DW{1'b0}};
        busy    = !wb_rst_i && ((state_r != ST_IDLE) || (|pipe_vld_r));
    end

endmodule

// File: tb/tb_bram_burst_scheduler.sv
// Directed self-checking bench for bram_burst_scheduler.
// Inputs change 1 time unit after the rising edge; outputs are checked
// on the falling edge. A small BRAM model returns pat(addr) with a
// two-cycle read latency.
module tb_bram_burst_scheduler;
    import bram_sched_pkg::*;

    localparam int NREQ = 3;
    localparam int AW   = 13;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_we    = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*4-1:0] req_len   = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0]   gnt, beat, rd_valid;
    logic [DW-1:0]     rd_data, bram_wdata;
    logic              rd_last, busy, bram_en, bram_we;
    logic [AW-1:0]     bram_addr;
    logic [DW-1:0]     bram_rdata = '0;
    logic [DW-1:0]     rd_p1 = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bram_burst_scheduler #(.NREQ(NREQ), .AW(AW), .DW(DW), .BRAM_LAT(2)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_len(req_len), .req_wdata(req_wdata),
        .gnt(gnt), .beat(beat), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_last(rd_last), .busy(busy), .bram_en(bram_en), .bram_we(bram_we),
        .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
    );

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return 32'hA500_0000 ^ {19'h0, a};
    endfunction

    // BRAM read model with two-cycle latency
    always @(posedge clk) begin
        rd_p1      <= (bram_en && !bram_we) ? pat(bram_addr) : 32'h0;
        bram_rdata <= rd_p1;
    end

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [3:0] len,
                           input logic [DW-1:0] wd);
        req_valid[i]         = v;
        req_we[i]            = we;
        req_addr[i*AW +: AW] = a;
        req_len[i*4 +: 4]    = len;
        req_wdata[i*DW +: DW] = wd;
    endtask

    task automatic clear_reqs();
        req_valid = '0; req_we = '0; req_addr = '0; req_len = '0; req_wdata = '0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        clear_reqs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vectors++;
            if ({gnt, beat, rd_valid, rd_last, busy, bram_en, bram_we} !== 13'h0 ||
                bram_addr !== 13'h0 || bram_wdata !== 32'h0 || rd_data !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_idle cyc%0d: got gnt=%b beat=%b rdv=%b last=%b busy=%b en=%b we=%b addr=%h wd=%h rd=%h, expected all 0",
                         k, gnt, beat, rd_valid, rd_last, busy, bram_en, bram_we, bram_addr, bram_wdata, rd_data);
            end
        end
    endtask

    task automatic test_read_burst();
        logic [2:0]  exp_beat;
        logic [12:0] exp_addr;
        logic [2:0]  exp_rdv;
        logic [31:0] exp_rd;
        logic        exp_last, exp_busy;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            if (k < 4) set_req(REQ_DMA_RD, 1'b1, 1'b0, 13'h010, 4'd3, 32'h0);
            else       clear_reqs();
            @(negedge clk);
            exp_beat = (k < 4) ? 3'b100 : 3'b000;
            exp_addr = (k < 4) ? 13'(13'h010 + k) : 13'h0;
            exp_rdv  = (k >= 2 && k <= 5) ? 3'b100 : 3'b000;
            exp_rd   = (k >= 2 && k <= 5) ? pat(13'(13'h010 + k - 2)) : 32'h0;
            exp_last = (k == 5);
            exp_busy = (k >= 1 && k <= 5);
            vectors++;
            if (beat !== exp_beat || gnt !== exp_beat || bram_addr !== exp_addr || bram_we !== 1'b0) begin
                miscompares++;
                $display("FAIL read_beat cyc%0d: got beat=%b gnt=%b addr=%h we=%b, expected beat=gnt=%b addr=%h we=0",
                         k, beat, gnt, bram_addr, bram_we, exp_beat, exp_addr);
            end
            vectors++;
            if (rd_valid !== exp_rdv || rd_data !== exp_rd || rd_last !== exp_last) begin
                miscompares++;
                $display("FAIL read_return cyc%0d: got rdv=%b data=%h last=%b, expected rdv=%b data=%h last=%b",
                         k, rd_valid, rd_data, rd_last, exp_rdv, exp_rd, exp_last);
            end
            vectors++;
            if (busy !== exp_busy) begin
                miscompares++;
                $display("FAIL read_busy cyc%0d: got %b, expected %b", k, busy, exp_busy);
            end
        end
    endtask

    task automatic test_write_wrap();
        logic [12:0] exp_a [4];
        logic [2:0]  exp_beat [4];
        exp_a    = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0777};
        exp_beat = '{3'b010, 3'b010, 3'b010, 3'b001};
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (k < 3) set_req(REQ_DMA_WR, 1'b1, 1'b1, 13'h1FFE, 4'd2, 32'(32'hBEEF_0000 + k));
            else       set_req(REQ_DMA_WR, 1'b0, 1'b0, 13'h0, 4'd0, 32'h0);
            if (k >= 1 && k <= 3) set_req(REQ_CACHE, 1'b1, 1'b0, 13'h0777, 4'd0, 32'h0);
            else                  set_req(REQ_CACHE, 1'b0, 1'b0, 13'h0, 4'd0, 32'h0);
            @(negedge clk);
            if (k < 4) begin
                vectors++;
                if (beat !== exp_beat[k] || bram_addr !== exp_a[k] || bram_we !== (k < 3)) begin
                    miscompares++;
                    $display("FAIL write_beat cyc%0d: got beat=%b addr=%h we=%b, expected beat=%b addr=%h we=%b",
                             k, beat, bram_addr, bram_we, exp_beat[k], exp_a[k], (k < 3));
                end
                if (k < 3) begin
                    vectors++;
                    if (bram_wdata !== 32'(32'hBEEF_0000 + k)) begin
                        miscompares++;
                        $display("FAIL write_data cyc%0d: got %h, expected %h", k, bram_wdata, 32'(32'hBEEF_0000 + k));
                    end
                end
            end else begin
                vectors++;
                if (beat !== 3'b000 || bram_en !== 1'b0) begin
                    miscompares++;
                    $display("FAIL write_done: got beat=%b en=%b, expected 000/0", beat, bram_en);
                end
            end
        end
    endtask

    task automatic test_rr_order();
        logic [2:0] exp_g;
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 1'b0, 13'(13'h020 + i), 4'd0, 32'h0);
            @(negedge clk);
`ifdef BRAM_SCHED_PRIO_EN
            exp_g = 3'b001;
`else
            exp_g = 3'(3'b001 << (k % 3));
`endif
            vectors++;
            if (gnt !== exp_g || beat !== exp_g) begin
                miscompares++;
                $display("FAIL rr_order cyc%0d: got gnt=%b beat=%b, expected %b", k, gnt, beat, exp_g);
            end
        end
        @(posedge clk); #1;
        clear_reqs();
        repeat (4) @(posedge clk);
    endtask

    task automatic test_abort();
        int n_rdv = 0;
        int n_last = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            clear_reqs();
            if (k < 4) set_req(REQ_CACHE, 1'b1, 1'b0, 13'h100, 4'd7, 32'h0);
            if (k == 4 || k == 5) set_req(REQ_DMA_WR, 1'b1, 1'b1, 13'h055, 4'd0, 32'h1234_5678);
            @(negedge clk);
            if (rd_valid[0] === 1'b1) n_rdv++;
            if (rd_last === 1'b1) n_last++;
            if (k < 4) begin
                vectors++;
                if (beat !== 3'b001 || bram_addr !== 13'(13'h100 + k)) begin
                    miscompares++;
                    $display("FAIL abort_beat cyc%0d: got beat=%b addr=%h, expected 001/%h", k, beat, bram_addr, 13'(13'h100 + k));
                end
            end else if (k == 4) begin
                vectors++;
                if (beat !== 3'b000 || bram_en !== 1'b0 || gnt !== 3'b001) begin
                    miscompares++;
                    $display("FAIL abort_drop: got beat=%b en=%b gnt=%b, expected 000/0/001", beat, bram_en, gnt);
                end
            end else if (k == 5) begin
                vectors++;
                if (gnt !== 3'b010 || beat !== 3'b010 || bram_we !== 1'b1 || bram_addr !== 13'h055) begin
                    miscompares++;
                    $display("FAIL abort_next: got gnt=%b beat=%b we=%b addr=%h, expected 010/010/1/055", gnt, beat, bram_we, bram_addr);
                end
            end else begin
                vectors++;
                if (beat !== 3'b000) begin
                    miscompares++;
                    $display("FAIL abort_quiet cyc%0d: got beat=%b, expected 000", k, beat);
                end
            end
        end
        vectors++;
        if (n_rdv != 4 || n_last != 0) begin
            miscompares++;
            $display("FAIL abort_returns: got %0d rd_valid %0d rd_last, expected 4 and 0", n_rdv, n_last);
        end
    endtask

    task automatic test_reset_mid_burst();
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            if (k < 2) set_req(REQ_DMA_RD, 1'b1, 1'b0, 13'h200, 4'd5, 32'h0);
            else       clear_reqs();
            rst = (k == 1);
            @(negedge clk);
            if (k == 0) begin
                vectors++;
                if (beat !== 3'b100) begin
                    miscompares++;
                    $display("FAIL rstmid_start: got beat=%b, expected 100", beat);
                end
            end else if (k >= 2) begin
                vectors++;
                if (gnt !== 3'b000 || beat !== 3'b000 || rd_valid !== 3'b000 || busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rstmid_after cyc%0d: got gnt=%b beat=%b rdv=%b busy=%b, expected all 0",
                             k, gnt, beat, rd_valid, busy);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_burst();
        test_write_wrap();
        test_rr_order();
        test_abort();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
